// File: rtl/alu_pkg.sv
// Shared ALU types: B-operand conditioning modes and skid buffer states.
package alu_pkg;

    typedef enum logic [1:0] {
        B_PASS = 2'b00,
        B_NEG  = 2'b01,
        B_INV  = 2'b10,
        B_ABS  = 2'b11
    } b_mode_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_TWO   = 2'b10
    } skid_state_t;

    localparam int unsigned B_FLAG_W = 2;

endpackage

// File: rtl/b_condition.sv
// Combinational B-operand conditioning: pass, negate, invert, abs.
module b_condition
    import alu_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter bit          SAT = 1'b0
) (
    input  logic [N-1:0] b_i,
    input  logic [1:0]   mode_i,
    output logic [N-1:0] result_o,
    output logic         carry_o,
    output logic         ovf_o
);

    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};

    b_mode_t      mode;
    logic         neg;
    logic         flip;
    logic [N-1:0] x;
    logic [N-1:0] sum;

    // Negation is built as xor-mask followed by +1, shared with invert.
    always_comb begin
        mode = b_mode_t'(mode_i);
        neg  = (mode == B_NEG) | ((mode == B_ABS) & b_i[N-1]);
        flip = neg | (mode == B_INV);
        x    = b_i ^ {N{flip}};
        {carry_o, sum} = {1'b0, x} + {{N{1'b0}}, neg};
        ovf_o = ((mode == B_NEG) | (mode == B_ABS)) & (b_i == MIN_VAL);
        result_o = (SAT && ovf_o) ? MAX_VAL : sum;
    end

endmodule

// File: rtl/b_operand_stage.sv
// Pipelined B-operand conditioning stage with 2-entry skid buffer.
module b_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter bit          SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] b_i,
    input  logic [1:0]   mode_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry_o,
    output logic         ovf_o,
    output logic         ovf_sticky,
    input  logic         clr_sticky
);

    typedef struct packed {
        logic [N-1:0] result;
        logic         carry;
        logic         ovf;
    } b_payload_t;

    skid_state_t state, state_n;
    b_payload_t  main_q, skid_q, cond;
    logic        in_ready_q;
    logic        in_xfer, out_xfer;
    logic        load_main, load_skid, pop_skid;

    b_condition #(.N(N), .SAT(SAT)) u_cond (
        .b_i      (b_i),
        .mode_i   (mode_i),
        .result_o (cond.result),
        .carry_o  (cond.carry),
        .ovf_o    (cond.ovf)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state != SKID_EMPTY);
    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid & out_ready;
    assign result    = main_q.result;
    assign carry_o   = main_q.carry;
    assign ovf_o     = main_q.ovf;

    always_comb begin
        state_n   = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        unique case (state)
            SKID_EMPTY: begin
                if (in_xfer) begin
                    state_n   = SKID_ONE;
                    load_main = 1'b1;
                end
            end
            SKID_ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_n   = SKID_TWO;
                    load_skid = 1'b1;
                end else if (in_xfer) begin
                    load_main = 1'b1;
                end else if (out_xfer) begin
                    state_n = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (out_xfer) begin
                    state_n  = SKID_ONE;
                    pop_skid = 1'b1;
                end
            end
            default: state_n = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SKID_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_n;
            in_ready_q <= (state_n != SKID_TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)
                main_q <= cond;
            else if (pop_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= cond;
        end
    end

    // Clear wins over a set in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (clr_sticky)
            ovf_sticky <= 1'b0;
        else if (out_xfer && main_q.ovf)
            ovf_sticky <= 1'b1;
    end

endmodule

// File: tb/tb_b_operand_stage.sv
// Directed bench for b_operand_stage, N=8, SAT=0 and SAT=1 instances.
module tb_b_operand_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready, in_ready_s;
    logic [7:0] b_i;
    logic [1:0] mode_i;
    logic       out_valid, out_valid_s;
    logic       out_ready;
    logic [7:0] result, result_s;
    logic       carry_o, carry_s;
    logic       ovf_o, ovf_s;
    logic       ovf_sticky, sticky_s;
    logic       clr_sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    b_operand_stage #(.N(8), .SAT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .b_i        (b_i),
        .mode_i     (mode_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carry_o    (carry_o),
        .ovf_o      (ovf_o),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
    );

    b_operand_stage #(.N(8), .SAT(1'b1)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready_s),
        .b_i        (b_i),
        .mode_i     (mode_i),
        .out_valid  (out_valid_s),
        .out_ready  (out_ready),
        .result     (result_s),
        .carry_o    (carry_s),
        .ovf_o      (ovf_s),
        .ovf_sticky (sticky_s),
        .clr_sticky (clr_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {result, carry, ovf} for SAT=0.
    function automatic logic [9:0] model(input logic [7:0] b,
                                         input logic [1:0] m);
        logic [7:0] r;
        logic       c;
        logic       v;
        r = b;
        c = 1'b0;
        v = 1'b0;
        case (m)
            2'b01: begin r = 8'(0 - b); c = (b == 8'h00); v = (b == 8'h80); end
            2'b10: r = ~b;
            2'b11: if (b[7]) begin
                r = 8'(0 - b); c = (b == 8'h00); v = (b == 8'h80);
            end
            default: ;
        endcase
        return {r, c, v};
    endfunction

    initial begin
        logic [9:0] exp_v;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        b_i        = 8'h00;
        mode_i     = 2'b00;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_payload", {result, carry_o, ovf_o, ovf_sticky}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        in_valid = 1'b1; b_i = 8'h05; mode_i = 2'b01;
        step();
        in_valid = 1'b0;
        chk("neg05", {out_valid, result, carry_o, ovf_o}, {1'b1, 8'hFB, 2'b00});

        in_valid = 1'b1; b_i = 8'h00; mode_i = 2'b01;
        step();
        chk("neg00", {out_valid, result, carry_o, ovf_o}, {1'b1, 8'h00, 2'b10});
        b_i = 8'h80; mode_i = 2'b11;
        step();
        in_valid = 1'b0;
        chk("abs80", {result, carry_o, ovf_o}, {8'h80, 2'b01});
        chk("abs80_sat", {result_s, ovf_s}, {8'h7F, 1'b1});
        chk("sticky_pre", 32'(ovf_sticky), 32'd0);
        step();
        chk("sticky_set", {out_valid, ovf_sticky}, 2'b01);
        chk("sticky_set_sat", 32'(sticky_s), 32'd1);

        out_ready = 1'b0;
        in_valid = 1'b1; b_i = 8'h01; mode_i = 2'b10;
        step();
        chk("bb_first", {out_valid, in_ready, result}, {2'b11, 8'hFE});
        b_i = 8'h02;
        step();
        chk("bb_full", {out_valid, in_ready, result}, {2'b10, 8'hFE});
        b_i = 8'h03;
        step();
        chk("bb_hold", {out_valid, in_ready, result}, {2'b10, 8'hFE});
        out_ready = 1'b1;
        step();
        chk("bb_out2", {out_valid, in_ready, result}, {2'b11, 8'hFD});
        step();
        in_valid = 1'b0;
        chk("bb_out3", {out_valid, result}, {1'b1, 8'hFC});
        step();
        chk("bb_drain", 32'(out_valid), 32'd0);

        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            b_i    = 8'($urandom_range(0, 255));
            mode_i = 2'($urandom_range(0, 3));
            if (i % 10 == 0) b_i = 8'h80;
            exp_v  = model(b_i, mode_i);
            step();
            chk($sformatf("stream%0d", i),
                {out_valid, in_ready, result, carry_o, ovf_o},
                {2'b11, exp_v});
        end
        in_valid = 1'b0;
        step();

        out_ready = 1'b0;
        in_valid = 1'b1; b_i = 8'h11; mode_i = 2'b00;
        step();
        b_i = 8'h22;
        step();
        chk("two_state", {out_valid, in_ready}, 2'b10);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {out_valid, in_ready, ovf_sticky}, 3'b010);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("no_ghost", 32'(out_valid), 32'd0);

        in_valid = 1'b1; b_i = 8'h80; mode_i = 2'b01;
        step();
        in_valid = 1'b0;
        step();
        chk("sticky_again", 32'(ovf_sticky), 32'd1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        clr_sticky = 1'b1;
        chk("clr_pre", {out_valid, ovf_o, ovf_sticky}, 3'b111);
        step();
        clr_sticky = 1'b0;
        chk("clr_wins", 32'(ovf_sticky), 32'd0);
        step();
        chk("clr_hold", 32'(ovf_sticky), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/b_operand_stage.md
Name: b_operand_stage

Overview:
- Parametrised, pipelined successor to the ALU B-operand conditioning logic.
- Accepts an N-bit B operand plus a mode, and produces the conditioned operand with status flags. Modes: pass, two's-complement negate, ones-complement invert, absolute value.
- Sits between the operand register file read and the ALU adder input.
- Uses valid/ready handshakes on both sides. A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- N, 32, operand width in bits (N >= 2).
- SAT, 0, when 1, negate/abs of the most-negative value saturates to the most-positive value instead of wrapping.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers an operand.
- in_ready  output  1  stage can accept; registered output.
- b_i  input  N  raw B operand (two's complement).
- mode_i  input  2  00 pass, 01 negate, 10 invert, 11 abs.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- result  output  N  conditioned operand.
- carry_o  output  1  carry-out of the +1 in negate/abs; 0 for pass/invert.
- ovf_o  output  1  result not representable (negate/abs of 100..0).
- ovf_sticky  output  1  OR of all ovf_o accepted downstream since reset or clear.
- clr_sticky  input  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset (rst_n low, asynchronous): both buffer entries invalid, out_valid=0, in_ready=1, result=0, carry_o=0, ovf_o=0, ovf_sticky=0.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Compute, combinational on accept:
  - pass: x = b_i.
  - invert: x = ~b_i.
  - negate: x = ~b_i + 1, carry = carry-out of that add.
  - abs: negate if b_i[N-1]=1, else pass with carry=0.
- Width and overflow:
  - All arithmetic is N bits.
  - ovf = 1 iff mode is negate/abs and b_i = 1 followed by N-1 zeros.
  - SAT=1 with ovf: result = 0 followed by N-1 ones. ovf stays 1.
  - Carry for negate of 0 is 1 (result 0).
- Latency: exactly 1 cycle from input transfer to out_valid when the output is empty or draining.
- Skid buffer states: EMPTY, ONE, TWO (entries main and skid).
  - EMPTY: accept → ONE (main loaded).
  - ONE, accept and no output transfer → TWO (skid loaded), in_ready drops next cycle.
  - ONE, accept with output transfer → ONE (main reloaded).
  - ONE, output transfer only → EMPTY.
  - TWO: in_ready=0; output transfer → ONE, with skid moved to main and in_ready=1 next cycle.
- Outputs driven from main entry only. result/carry_o/ovf_o hold stable while out_valid=1 and out_ready=0.
- in_ready = (state != TWO), registered.
- ovf_sticky:
  - Set on an output transfer with ovf_o=1.
  - clr_sticky takes priority over a simultaneous set. Value is 0 next cycle.
- Reset mid-operation discards all buffered entries with no output transfer.
- in_valid with in_ready=0 has no effect. Upstream holds data (standard rule, not checked).

Decomposition:
- Shared package alu_pkg:
  - enum b_mode_t {B_PASS, B_NEG, B_INV, B_ABS}.
  - Typedef for the payload struct {result, carry, ovf} parameterised by N through a localparam or macro.
- Sub-module b_condition (combinational, N, SAT): b_i, mode → result, carry, ovf. The existing xor-then-add structure generalises into this.
- Top holds the skid buffer FSM and the sticky flag.

Test Plan:
- N=8, SAT=0, out_ready=1, one beat of b=0x05, mode=01 → next cycle out_valid=1, result=0xFB, carry=0, ovf=0.
- N=8, negate b=0x00 → result=0x00, carry=1. Abs b=0x80 → result=0x80, ovf=1, ovf_sticky=1 after the transfer. Same with SAT=1 → result=0x7F, ovf=1.
- Back-to-back inputs 0x01,0x02,0x03 (mode 10) with out_ready low for 2 cycles:
  - in_ready drops after the 2nd accept.
  - out_valid held with result=0xFE stable.
  - On release, outputs 0xFE, 0xFD, 0xFC in order, none lost or duplicated.
- Streaming 100 random beats with out_ready=1 and in_valid=1 → throughput 1 beat/cycle, in_ready stays 1, results match the reference model.
- Assert rst_n low while in state TWO → out_valid=0 and in_ready=1 immediately (asynchronous). No outputs for the discarded entries after rst_n returns high.
- ovf_sticky=1, then clr_sticky=1 in the same cycle as an output transfer with ovf=1 → ovf_sticky=0 next cycle.
